// File: rtl/icache_refill_ctrl_pkg.sv
// Shared parameters and types for the instruction-cache refill sequencer.
package icache_refill_ctrl_pkg;

    localparam int CPU_WORD            = 32;
    localparam int CPU_LINE_WORDS      = 4;
    localparam int CPU_ADDR_W          = 32;
    localparam int CACHE_LINE_WIDTH    = CPU_WORD * CPU_LINE_WORDS;
    localparam int CACHE_LINE_BYTE_LOG = $clog2(CACHE_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2,
        S_FILL = 2'd3
    } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl_refill_line_asm.sv
// Beat counter and word-indexed line assembly register for a refill burst.
// The counter saturates at LINE_WORDS so surplus beats of a long burst are
// dropped, and words never written by a short burst stay at zero.
module refill_line_asm #(
    parameter int WORD       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WORD-1:0]            wr_data,
    output logic [WORD*LINE_WORDS-1:0] line
);

    localparam int CNT_W = $clog2(LINE_WORDS) + 1;

    logic [CNT_W-1:0] count;

    // Clear on reset or burst start; otherwise place each beat at the counter slot.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            line  <= '0;
            count <= '0;
        end else if (wr_en && (count < CNT_W'(LINE_WORDS))) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (count == CNT_W'(i)) begin
                    line[i*WORD +: WORD] <= wr_data;
                end
            end
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one burst read per miss, assemble the line,
// then a single-cycle fill into the return buffer and the cache arrays.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int WORD       = CPU_WORD,
    parameter int LINE_WORDS = CPU_LINE_WORDS,
    parameter int ADDR_W     = CPU_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_req,
    input  logic [ADDR_W-1:0]          miss_addr,
    input  logic                       flush,
    output logic                       rd_req,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_rdy,
    input  logic                       ret_valid,
    input  logic                       ret_last,
    input  logic [WORD-1:0]            ret_data,
    output logic [WORD*LINE_WORDS-1:0] line_out,
    output logic                       buf_we,
    output logic                       mem_we,
    output logic                       refill_done,
    output logic                       busy
);

    localparam int BYTE_LOG = $clog2(WORD * LINE_WORDS / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << BYTE_LOG) - 64'd1);

    refill_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              drop_q;
    logic              asm_clear;
    logic              asm_wr;

    refill_line_asm #(
        .WORD       (WORD),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .wr_en   (asm_wr),
        .wr_data (ret_data),
        .line    (line_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and assembly control; a flush on the last beat also drops the line.
    always_comb begin
        state_d   = state_q;
        asm_clear = 1'b0;
        asm_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_req && !flush) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (rd_rdy) begin
                    asm_clear = 1'b1;
                    state_d   = S_RECV;
                end
            end
            S_RECV: begin
                asm_wr = ret_valid;
                if (ret_valid && ret_last) begin
                    state_d = (drop_q || flush) ? S_IDLE : S_FILL;
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latch the line-aligned miss address and track the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            drop_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && miss_req && !flush) begin
                addr_q <= miss_addr & LINE_MASK;
            end
            if (state_q == S_REQ) begin
                drop_q <= 1'b0;
            end else if (state_q == S_RECV && flush) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Outputs decoded from state or taken from registers only.
    always_comb begin
        rd_req      = (state_q == S_REQ);
        rd_addr     = addr_q;
        buf_we      = (state_q == S_FILL);
        mem_we      = (state_q == S_FILL);
        refill_done = (state_q == S_FILL);
        busy        = (state_q != S_IDLE);
    end

endmodule
